// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial bit source.
// Build option: SER_PARITY_EN appends an even-parity bit to each word.
package ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to hold values 0..max_val (never less than one).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: strobes the first and last clk cycle of each bit.
// Counter sits at zero while run is low, so each word starts aligned.
module bit_tick_gen
  import ser_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_start,
  output logic bit_end
);

  localparam int DW = cnt_w(DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!run || div_cnt == DMAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bit_start = run && (div_cnt == '0);
  assign bit_end   = run && (div_cnt == DMAX);

endmodule

// File: rtl/ser_bit_src.sv
// Parallel-to-serial feeder, LSB first, one bit_en strobe per bit.
// Build option: SER_PARITY_EN adds a trailing even-parity bit.
module ser_bit_src
  import ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_en,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  localparam int BW = cnt_w(NBITS - 1);
  localparam logic [BW-1:0] BLAST = BW'(NBITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] word;
  logic [BW-1:0]    bcnt;
  logic             run;
  logic             bit_start;
  logic             bit_end;
  logic             last;
  logic             load;

  assign run  = (state == ST_SHIFT);
  assign last = run && bit_end && (bcnt == BLAST);
  assign load = data_valid && data_ready;

`ifdef SER_PARITY_EN
  assign word = {^data_in, data_in};
`else
  assign word = data_in;
`endif

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last) state_nxt = load ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Word end reloads directly, so back-to-back words have no gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shreg <= word;
        bcnt  <= '0;
      end else if (run && bit_end) begin
        shreg <= {1'b0, shreg[NBITS-1:1]};
        bcnt  <= last ? '0 : bcnt + 1'b1;
      end
    end
  end

  assign data_ready = !run || last;
  assign bit_out    = run && shreg[0];
  assign bit_en     = bit_start;
  assign busy       = run;

endmodule

// File: tb/tb_ser_bit_src.sv
// Self-checking bench for ser_bit_src with DIV=1 and DIV=3 instances.
// Expected waveforms come from a word/bit-period model of the serializer.
module tb_ser_bit_src;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   dv;
  logic [1:0]   bo;
  logic [1:0]   be;
  logic [1:0]   by;
  logic [1:0]   rd;
  logic [W-1:0] din [2];
  logic [W-1:0] wq [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ser_bit_src #(.WIDTH(W), .DIV(1)) u_div1 (
    .clk(clk), .reset(reset),
    .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rd[0]), .bit_out(bo[0]),
    .bit_en(be[0]), .busy(by[0])
  );

  ser_bit_src #(.WIDTH(W), .DIV(3)) u_div3 (
    .clk(clk), .reset(reset),
    .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rd[1]), .bit_out(bo[1]),
    .bit_en(be[1]), .busy(by[1])
  );

  // Serial bit idx of a word: data LSB first, then even parity.
  function automatic logic model_bit(
    input logic [W-1:0] w, input int idx);
    return (idx < W) ? w[idx] : ^w;
  endfunction

  // Streams wq through DUT s (bit period d), words back to back.
  task automatic run_words(input int s, input int d, input string tag);
    int len;
    logic eb, ee, er;
    len = NB * d;
    @(posedge clk); #1;
    dv[s] = 1'b1;
    din[s] = wq[0];
    @(negedge clk);
    n_checks++;
    if (rd[s] !== 1'b1 || by[s] !== 1'b0 || be[s] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: ready=%b busy=%b en=%b required 1 0 0",
               tag, rd[s], by[s], be[s]);
    end
    foreach (wq[j]) begin
      @(posedge clk); #1;
      if (j + 1 < wq.size()) din[s] = wq[j+1];
      else begin
        dv[s] = 1'b0;
        din[s] = W'($urandom);
      end
      for (int i = 0; i < len; i++) begin
        if (i > 0) begin
          @(posedge clk); #1;
          if (!dv[s]) din[s] = W'($urandom);
        end
        @(negedge clk);
        eb = model_bit(wq[j], i / d);
        ee = (i % d == 0);
        er = (i == len - 1);
        n_checks++;
        if ({bo[s], be[s], by[s], rd[s]} !== {eb, ee, 1'b1, er}) begin
          n_fail++;
          $display("FAIL %s word%0d cyc%0d: out/en/busy/ready=%b%b%b%b required %b%b1%b",
                   tag, j, i, bo[s], be[s], by[s], rd[s], eb, ee, er);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bo[s], be[s], by[s], rd[s]} !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s end_idle: out/en/busy/ready=%b%b%b%b required 0001",
               tag, bo[s], be[s], by[s], rd[s]);
    end
  endtask

  task automatic test_reset;
    #12;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({bo[s], be[s], by[s], rd[s]} !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset dut%0d: out/en/busy/ready=%b%b%b%b required 0001",
                 s, bo[s], be[s], by[s], rd[s]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single;
    wq = '{8'h07};
    run_words(0, 1, "single_07");
  endtask

  task automatic test_back_to_back;
    wq = '{8'hA5, 8'h3C};
    run_words(0, 1, "b2b_a5_3c");
  endtask

  task automatic test_div3;
    wq = '{8'h81};
    run_words(1, 3, "div3_81");
  endtask

  task automatic test_parity;
    wq = '{8'h07};
    run_words(0, 1, "parity_07");
    wq = '{8'h03};
    run_words(1, 3, "parity_03");
  endtask

  task automatic test_abort;
    @(posedge clk); #1;
    dv[0] = 1'b1;
    din[0] = 8'hFF;
    @(posedge clk); #1;
    dv[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bo[0], be[0], by[0]} !== 3'b111) begin
        n_fail++;
        $display("FAIL abort_pre bit%0d: out/en/busy=%b%b%b required 111",
                 i, bo[0], be[0], by[0]);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bo[0], be[0], by[0], rd[0]} !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort_async: out/en/busy/ready=%b%b%b%b required 0001",
               bo[0], be[0], by[0], rd[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    wq = '{8'h01};
    run_words(0, 1, "abort_restart");
  endtask

  task automatic test_random;
    int s;
    int n;
    repeat (8) begin
      s = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(W'($urandom));
      run_words(s, (s == 0) ? 1 : 3, "random");
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
    end
  endtask

  initial begin
    dv = 2'b00;
    din[0] = '0;
    din[1] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_div3();
    test_parity();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
